// File: rtl/controlador_display_multiplexado_pkg.sv
// Shared definitions for the multiplexed seven-segment display controller:
// scan state encoding and active-low {g,f,e,d,c,b,a} glyph constants.
package pkg_display;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        MOSTRAR  = 2'd1,
        GUARDA   = 2'd2
    } estado_t;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_APAGADO = 7'b1111111;

endpackage

// File: rtl/controlador_display_multiplexado_deco.sv
// Combinational hex nibble to common-anode seven-segment decoder.
// Anything not a clean 0-F (e.g. X) falls back to all segments off.
module deco_siete_segmentos
    import pkg_display::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segmentos
);

    always_comb begin
        segmentos = SEG_APAGADO;
        case (nibble)
            4'h0:    segmentos = SEG_0;
            4'h1:    segmentos = SEG_1;
            4'h2:    segmentos = SEG_2;
            4'h3:    segmentos = SEG_3;
            4'h4:    segmentos = SEG_4;
            4'h5:    segmentos = SEG_5;
            4'h6:    segmentos = SEG_6;
            4'h7:    segmentos = SEG_7;
            4'h8:    segmentos = SEG_8;
            4'h9:    segmentos = SEG_9;
            4'hA:    segmentos = SEG_A;
            4'hB:    segmentos = SEG_B;
            4'hC:    segmentos = SEG_C;
            4'hD:    segmentos = SEG_D;
            4'hE:    segmentos = SEG_E;
            4'hF:    segmentos = SEG_F;
            default: segmentos = SEG_APAGADO;
        endcase
    end

endmodule

// File: rtl/controlador_display_multiplexado.sv
// Time-multiplexed seven-segment display controller with guard intervals and
// frame-boundary buffered loads. Define SUPRESION_CEROS_EN to blank leading zeros.
module controlador_display_multiplexado
    import pkg_display::*;
#(
    parameter int NUM_DIGITOS    = 4,
    parameter int CICLOS_MOSTRAR = 50000,
    parameter int CICLOS_GUARDA  = 500
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Habilitar,
    input  logic [4*NUM_DIGITOS-1:0] Valor,
    input  logic                     Cargar,
    output logic                     Listo,
    output logic [6:0]               Segmentos,
    output logic [NUM_DIGITOS-1:0]   Anodos
);

    localparam int MAXC = (CICLOS_MOSTRAR > CICLOS_GUARDA) ? CICLOS_MOSTRAR : CICLOS_GUARDA;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;

    localparam logic [CW-1:0] FIN_MOSTRAR = CW'(CICLOS_MOSTRAR - 1);
    localparam logic [CW-1:0] FIN_GUARDA  = CW'(CICLOS_GUARDA - 1);
    localparam logic [IW-1:0] ULTIMO      = IW'(NUM_DIGITOS - 1);

    estado_t                  estado, estado_sig;
    logic [IW-1:0]            indice, indice_sig;
    logic [CW-1:0]            cuenta, cuenta_sig;
    logic                     frontera;

    logic [4*NUM_DIGITOS-1:0] activo, pendiente;
    logic                     hay_pendiente;

    logic [3:0]               nibble;
    logic [6:0]               seg_deco;
    logic [NUM_DIGITOS-1:0]   anodo_sel;
    logic                     apagar;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= INACTIVO;
            indice <= '0;
            cuenta <= '0;
        end else begin
            estado <= estado_sig;
            indice <= indice_sig;
            cuenta <= cuenta_sig;
        end
    end

    // Counter only advances within a state; every transition clears it.
    always_comb begin
        estado_sig = estado;
        indice_sig = indice;
        cuenta_sig = cuenta + CW'(1);
        frontera   = 1'b0;
        if (!Habilitar) begin
            estado_sig = INACTIVO;
            indice_sig = '0;
            cuenta_sig = '0;
        end else begin
            case (estado)
                INACTIVO: begin
                    estado_sig = MOSTRAR;
                    indice_sig = '0;
                    cuenta_sig = '0;
                end
                MOSTRAR: begin
                    if (cuenta == FIN_MOSTRAR) begin
                        estado_sig = GUARDA;
                        cuenta_sig = '0;
                    end
                end
                GUARDA: begin
                    if (cuenta == FIN_GUARDA) begin
                        estado_sig = MOSTRAR;
                        cuenta_sig = '0;
                        if (indice == ULTIMO) begin
                            indice_sig = '0;
                            frontera   = 1'b1;
                        end else begin
                            indice_sig = indice + IW'(1);
                        end
                    end
                end
                default: begin
                    estado_sig = INACTIVO;
                    indice_sig = '0;
                    cuenta_sig = '0;
                end
            endcase
        end
    end

    // A pending frame is promoted only where no scan can tear: frame boundary or idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            activo        <= '0;
            pendiente     <= '0;
            hay_pendiente <= 1'b0;
        end else if (hay_pendiente && (estado == INACTIVO || frontera)) begin
            activo        <= pendiente;
            hay_pendiente <= 1'b0;
        end else if (Cargar && !hay_pendiente) begin
            pendiente     <= Valor;
            hay_pendiente <= 1'b1;
        end
    end

    assign Listo = ~hay_pendiente;

    always_comb begin
        nibble    = '0;
        anodo_sel = '1;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (indice == IW'(i)) begin
                nibble       = activo[4*i +: 4];
                anodo_sel[i] = 1'b0;
            end
        end
    end

`ifdef SUPRESION_CEROS_EN
    // Walk down from the top digit; a digit is blank while everything above and including it is zero.
    always_comb begin
        logic todo_cero;
        todo_cero = 1'b1;
        apagar    = 1'b0;
        for (int i = NUM_DIGITOS - 1; i > 0; i--) begin
            todo_cero = todo_cero && (activo[4*i +: 4] == 4'h0);
            if (todo_cero && (indice == IW'(i)))
                apagar = 1'b1;
        end
    end
`else
    assign apagar = 1'b0;
`endif

    deco_siete_segmentos u_deco (
        .nibble    (nibble),
        .segmentos (seg_deco)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            Anodos    <= '1;
            Segmentos <= SEG_APAGADO;
        end else if (estado == MOSTRAR && !apagar) begin
            Anodos    <= anodo_sel;
            Segmentos <= seg_deco;
        end else begin
            Anodos    <= '1;
            Segmentos <= SEG_APAGADO;
        end
    end

endmodule

// File: tb/tb_controlador_display_multiplexado.sv
// Bench for controlador_display_multiplexado: directed and random steps checked
// every cycle against a time-position model of the scan.
module tb_controlador_display_multiplexado;

    localparam int N = 4;
    localparam int M = 4;
    localparam int G = 2;
    localparam int P = M + G;

    logic          clk = 1'b0;
    logic          rst;
    logic          hab;
    logic [15:0]   valor;
    logic          cargar;
    logic          listo;
    logic [6:0]    segs;
    logic [3:0]    anodos;

    int n_checks = 0;
    int n_err    = 0;

    // Model: m_pos = cycles since the scan started (-1 when idle).
    int            m_pos;
    logic [15:0]   m_act;
    logic [15:0]   m_pv;
    bit            m_pend;
    logic [3:0]    e_an;
    logic [6:0]    e_seg;

    logic [6:0] glifo [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    controlador_display_multiplexado #(
        .NUM_DIGITOS    (N),
        .CICLOS_MOSTRAR (M),
        .CICLOS_GUARDA  (G)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .Habilitar (hab),
        .Valor     (valor),
        .Cargar    (cargar),
        .Listo     (listo),
        .Segmentos (segs),
        .Anodos    (anodos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit en_blanco(input int d);
`ifdef SUPRESION_CEROS_EN
        return (d > 0) && ((m_act >> (4*d)) == 16'h0);
`else
        return (d < 0);
`endif
    endfunction

    task automatic tick();
        int  d;
        int  ph;
        bit  pend_old;
        bit  frontera;
        @(posedge clk);
        if (rst) begin
            m_pos  = -1;
            m_act  = '0;
            m_pv   = '0;
            m_pend = 1'b0;
            e_an   = 4'hF;
            e_seg  = 7'h7F;
        end else begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            if (m_pos >= 0) begin
                d  = (m_pos / P) % N;
                ph = m_pos % P;
                if (ph < M && !en_blanco(d)) begin
                    e_an  = ~(4'b0001 << d);
                    e_seg = glifo[4'((m_act >> (4*d)) & 16'hF)];
                end
            end
            pend_old = m_pend;
            frontera = hab && (m_pos >= 0) && (((m_pos + 1) % (N*P)) == 0);
            if (cargar && !pend_old) begin
                m_pv   = valor;
                m_pend = 1'b1;
            end
            if (pend_old && (m_pos < 0 || frontera)) begin
                m_act  = m_pv;
                m_pend = 1'b0;
            end
            m_pos = hab ? m_pos + 1 : -1;
        end
        @(negedge clk);
        check("anodos", 16'(anodos), 16'(e_an));
        check("segmentos", 16'(segs), 16'(e_seg));
        check("listo", 16'(listo), 16'(!m_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [15:0] v);
        valor  = v;
        cargar = 1'b1;
        tick();
        cargar = 1'b0;
    endtask

    initial begin
        int cnt;
        rst    = 1'b1;
        hab    = 1'b0;
        valor  = '0;
        cargar = 1'b0;
        m_pos  = -1;
        m_act  = '0;
        m_pv   = '0;
        m_pend = 1'b0;
        @(negedge clk);
        run(3);

        // Free-running scan of the reset frame
        rst = 1'b0;
        hab = 1'b1;
        run(2 * N * P + 1);

        // Load mid digit 2, then a second load that must be ignored
        cnt = 0;
        while (((m_pos / P) % N) != 2 && cnt < 100) begin tick(); cnt++; end
        check("espera_digito2", 16'((m_pos / P) % N), 16'd2);
        tick();
        load(16'h3A7F);
        load(16'h1111);
        run(3 * N * P);

        // Load exactly on the frame-boundary edge
        cnt = 0;
        while (((m_pos + 1) % (N*P)) != 0 && cnt < 100) begin tick(); cnt++; end
        check("espera_frontera", 16'((m_pos + 1) % (N*P)), 16'd0);
        load(16'hC0DE);
        run(2 * N * P);

        // Drop Habilitar mid lit phase, then restart
        run(2);
        hab = 1'b0;
        run(4);
        hab = 1'b1;
        run(N * P + 3);

        // Load while idle: promoted without a scan
        hab = 1'b0;
        tick();
        load(16'h9B21);
        run(3);
        hab = 1'b1;
        run(N * P + 2);

        // Leading-zero frames
        load(16'h0005);
        run(2 * N * P);
        load(16'h0000);
        run(2 * N * P);
        load(16'h00F0);
        run(2 * N * P);

        // Random loads, random enables
        for (int k = 0; k < 12; k++) begin
            run($urandom_range(0, 30));
            if ($urandom_range(0, 3) == 0) begin
                hab = 1'b0;
                run($urandom_range(1, 4));
                hab = 1'b1;
            end
            load(16'($urandom));
            if ($urandom_range(0, 1) == 1) load(16'($urandom));
        end
        run(2 * N * P);

        // Reset while a load is pending
        run(5);
        load(16'h4321);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(2 * N * P);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
